// File: rtl/regfile_mp.sv
// Multi-port GPR file: NUM_RD combinational reads, two write-back ports, post-reset array clear and busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       set_busy,
  input  logic [ADDR_W-1:0]          busy_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                ready_q;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DEPTH-1:0]    busy_q;
  logic [DEPTH-1:0]    busy_d;

  // Clear sequencer: one entry per cycle, READY after entry DEPTH-1 is zeroed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == '1) begin
            state_q <= S_READY;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_READY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_q;

  // Port 1 is assigned last so it wins an address collision with port 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        regs_q[clr_cnt_q] <= '0;
      end else begin
        if (we0 && (waddr0 != '0)) regs_q[waddr0] <= wdata0;
        if (we1 && (waddr1 != '0)) regs_q[waddr1] <= wdata1;
      end
    end
  end

  // Retire write-back producers first so a same-cycle new producer keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (state_q == S_READY) begin
      if (we0) busy_d[waddr0] = 1'b0;
      if (we1) busy_d[waddr1] = 1'b0;
      if (set_busy && (busy_addr != '0)) busy_d[busy_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if ((state_q == S_READY) && re[i] && (raddr[i*ADDR_W +: ADDR_W] != '0)) begin
        rdata[i*DATA_W +: DATA_W] = regs_q[raddr[i*ADDR_W +: ADDR_W]];
        rbusy[i]                  = busy_q[raddr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
        if (we0 && (waddr0 == raddr[i*ADDR_W +: ADDR_W])) begin
          rdata[i*DATA_W +: DATA_W] = wdata0;
          rbusy[i]                  = 1'b0;
        end
        if (we1 && (waddr1 == raddr[i*ADDR_W +: ADDR_W])) begin
          rdata[i*DATA_W +: DATA_W] = wdata1;
          rbusy[i]                  = 1'b0;
        end
`endif
      end
    end
  end

endmodule
